// File: rtl/masked_xor_fold.sv
// masked_xor_fold: pipelined pairwise fold of Boolean shares, with ring refresh before each fold.
// Optional build macro FOLD_ZEROIZE_EN: stages receiving a bubble load all-zero data.
package masked_xor_fold_pkg;

    // Share count entering layer l.
    function automatic int unsigned m_at(input int unsigned n, input int unsigned l);
        int unsigned m;
        m = n;
        for (int unsigned i = 0; i < l; i++) m = (m + 1) / 2;
        return m;
    endfunction

    function automatic int unsigned layers(input int unsigned n, input int unsigned out_n);
        int unsigned m;
        int unsigned c;
        m = n;
        c = 0;
        while (m > out_n && m > 1) begin
            m = (m + 1) / 2;
            c++;
        end
        return c;
    endfunction

    // Word offset into rnd of the slice used by layer l.
    function automatic int unsigned rnd_off(input int unsigned n, input int unsigned l);
        int unsigned s;
        s = 0;
        for (int unsigned i = 0; i < l; i++) begin
            if (m_at(n, i) > 2) s += m_at(n, i);
        end
        return s;
    endfunction

    function automatic int unsigned rnd_words(input int unsigned n, input int unsigned out_n);
        return rnd_off(n, layers(n, out_n));
    endfunction

endpackage

module masked_xor_fold
    import masked_xor_fold_pkg::*;
#(
    parameter int unsigned K_WIDTH    = 32,
    parameter int unsigned N_SHARES   = 5,
    parameter int unsigned OUT_SHARES = 1,
    localparam int unsigned RANDNUM   = rnd_words(N_SHARES, OUT_SHARES),
    localparam int unsigned RND_W     = ((RANDNUM == 0) ? 1 : RANDNUM) * K_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ena,
    input  logic                             dvld,
    output logic                             i_rdy,
    input  logic [N_SHARES*K_WIDTH-1:0]      i_x,
    input  logic [RND_W-1:0]                 rnd,
    output logic [OUT_SHARES*K_WIDTH-1:0]    o_z,
    output logic                             ovld,
    input  logic                             o_rdy
);

    localparam int unsigned LAYERS = layers(N_SHARES, OUT_SHARES);
    // One zero pad share above the top keeps every fold select in range.
    localparam int unsigned SW     = (N_SHARES + 1) * K_WIDTH;
    localparam int unsigned M_LAST = m_at(N_SHARES, LAYERS - 1);

    if (N_SHARES < 2 || OUT_SHARES < 1 || OUT_SHARES >= N_SHARES) begin : g_bad_cfg
        $error("masked_xor_fold: need N_SHARES >= 2 and 1 <= OUT_SHARES < N_SHARES");
    end

    // Pairwise XOR of the first m shares; an odd last share passes through.
    function automatic logic [SW-1:0] fold(input logic [SW-1:0] s, input int unsigned m);
        logic [SW-1:0] r;
        r = '0;
        for (int unsigned j = 0; j < (N_SHARES + 1) / 2; j++) begin
            if (2 * j + 1 < m)
                r[j*K_WIDTH +: K_WIDTH] = s[2*j*K_WIDTH +: K_WIDTH] ^ s[(2*j+1)*K_WIDTH +: K_WIDTH];
            else if (2 * j + 1 == m)
                r[j*K_WIDTH +: K_WIDTH] = s[2*j*K_WIDTH +: K_WIDTH];
        end
        return r;
    endfunction

    logic          adv;
    logic [SW-1:0] z_full;
    logic          unused_z;

    assign adv   = ena && (!ovld || o_rdy);
    assign i_rdy = rst_n && adv;

    for (genvar l = 0; l < LAYERS; l++) begin : g_layer
        localparam int unsigned M = m_at(N_SHARES, l);

        logic [SW-1:0] src;
        logic [SW-1:0] refreshed;
        logic [SW-1:0] data_q;
        logic          src_vld;
        logic          vld_q;

        if (l == 0) begin : g_in
            assign src     = SW'(i_x);
            assign src_vld = dvld;
        end else begin : g_fold
            assign src     = fold(g_layer[l-1].data_q, m_at(N_SHARES, l - 1));
            assign src_vld = g_layer[l-1].vld_q;
        end

        // Each rnd word lands on two neighbouring shares, so the share XOR is unchanged.
        if (M > 2) begin : g_refresh
            localparam int unsigned ROFF = rnd_off(N_SHARES, l);
            always_comb begin
                refreshed = src;
                for (int unsigned i = 0; i < M; i++) begin
                    refreshed[i*K_WIDTH +: K_WIDTH] = src[i*K_WIDTH +: K_WIDTH]
                        ^ rnd[(ROFF + i)*K_WIDTH +: K_WIDTH]
                        ^ rnd[(ROFF + (i + 1) % M)*K_WIDTH +: K_WIDTH];
                end
            end
        end else begin : g_plain
            assign refreshed = src;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                data_q <= '0;
                vld_q  <= 1'b0;
            end else if (adv) begin
                vld_q  <= src_vld;
`ifdef FOLD_ZEROIZE_EN
                data_q <= src_vld ? refreshed : '0;
`else
                data_q <= refreshed;
`endif
            end
        end
    end

    // Last layer folds without randomness, so o_z only changes when the last stage loads.
    assign z_full   = fold(g_layer[LAYERS-1].data_q, M_LAST);
    assign o_z      = z_full[OUT_SHARES*K_WIDTH-1:0];
    assign ovld     = g_layer[LAYERS-1].vld_q;
    assign unused_z = ^z_full[SW-1:OUT_SHARES*K_WIDTH];

endmodule

// File: tb/tb_masked_xor_fold.sv
// Bench for masked_xor_fold: OUT_SHARES=1 and OUT_SHARES=2 instances against a slot-level XOR reference.
module tb_masked_xor_fold;

    localparam int unsigned K  = 32;
    localparam int unsigned N  = 5;
    localparam int unsigned L  = 3;
    localparam int unsigned L2 = 2;
    localparam int unsigned RW = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ena;
    logic           dvld;
    logic           o_rdy;
    logic [N*K-1:0] i_x;
    logic [RW*K-1:0] rnd;
    logic           i_rdy;
    logic           ovld;
    logic [K-1:0]   o_z;
    logic           i_rdy2;
    logic           ovld2;
    logic [2*K-1:0] o_z2;

    int checks = 0;
    int errors = 0;

    // Reference: each slot holds (valid, XOR of the shares of the word in it).
    bit           mv  [L];
    logic [K-1:0] mx  [L];
    bit           m2v [L2];
    logic [K-1:0] m2x [L2];
    bit           just_reset;

    masked_xor_fold #(.K_WIDTH(32), .N_SHARES(5), .OUT_SHARES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .dvld(dvld), .i_rdy(i_rdy),
        .i_x(i_x), .rnd(rnd), .o_z(o_z), .ovld(ovld), .o_rdy(o_rdy)
    );

    masked_xor_fold #(.K_WIDTH(32), .N_SHARES(5), .OUT_SHARES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .dvld(dvld), .i_rdy(i_rdy2),
        .i_x(i_x), .rnd(rnd), .o_z(o_z2), .ovld(ovld2), .o_rdy(1'b1)
    );

    always #5 clk = ~clk;

    function automatic logic [K-1:0] xor_all(input logic [N*K-1:0] x);
        logic [K-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r ^= x[i*K +: K];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic rand_x();
        for (int i = 0; i < N; i++) i_x[i*K +: K] = $urandom;
    endtask

    task automatic clear_model();
        for (int i = 0; i < L; i++) begin
            mv[i] = 1'b0;
            mx[i] = '0;
        end
        for (int i = 0; i < L2; i++) begin
            m2v[i] = 1'b0;
            m2x[i] = '0;
        end
    endtask

    // One clock: fresh rnd, check i_rdy before the edge, advance reference, check outputs after.
    task automatic step();
        bit adv;
        bit adv2;
        for (int i = 0; i < RW; i++) rnd[i*K +: K] = $urandom;
        #1;
        adv  = ena && (!mv[L-1] || o_rdy);
        adv2 = ena;
        check("i_rdy", 64'(i_rdy), 64'(rst_n && adv));
        check("i_rdy2", 64'(i_rdy2), 64'(rst_n && adv2));
        @(posedge clk);
        if (!rst_n) begin
            clear_model();
            just_reset = 1'b1;
        end else begin
            just_reset = 1'b0;
            if (adv) begin
                for (int i = L - 1; i > 0; i--) begin
                    mv[i] = mv[i-1];
                    mx[i] = mx[i-1];
                end
                mv[0] = dvld;
                mx[0] = xor_all(i_x);
            end
            if (adv2) begin
                for (int i = L2 - 1; i > 0; i--) begin
                    m2v[i] = m2v[i-1];
                    m2x[i] = m2x[i-1];
                end
                m2v[0] = dvld;
                m2x[0] = xor_all(i_x);
            end
        end
        #1;
        check("ovld", 64'(ovld), 64'(mv[L-1]));
        check("ovld2", 64'(ovld2), 64'(m2v[L2-1]));
        if (mv[L-1] || just_reset)
            check("o_z", 64'(o_z), 64'(mv[L-1] ? mx[L-1] : '0));
        if (m2v[L2-1])
            check("o_z2_share_xor", 64'(o_z2[K-1:0] ^ o_z2[2*K-1:K]), 64'(m2x[L2-1]));
        if (just_reset)
            check("o_z2_reset", o_z2, 64'h0);
`ifdef FOLD_ZEROIZE_EN
        if (!mv[L-1])
            check("o_z_bubble_zero", 64'(o_z), 64'h0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        dvld  = 1'b0;
        o_rdy = 1'b1;
        i_x   = '0;
        rnd   = '0;
        just_reset = 1'b0;
        clear_model();
        step();
        step();
        rst_n = 1'b1;

        // Single directed word, then drain.
        i_x  = {32'h10, 32'h8, 32'h4, 32'h2, 32'h1};
        dvld = 1'b1;
        step();
        dvld = 1'b0;
        repeat (4) step();

        // Same word back-to-back under changing randomness.
        dvld = 1'b1;
        repeat (100) step();

        // Random stream with a 4-cycle downstream stall mid-stream.
        for (int c = 0; c < 30; c++) begin
            rand_x();
            o_rdy = !(c >= 10 && c < 14);
            step();
        end
        o_rdy = 1'b1;

        // Global enable low freezes everything.
        ena = 1'b0;
        repeat (3) begin
            rand_x();
            step();
        end
        ena = 1'b1;

        // Three words in flight, then a one-cycle reset.
        repeat (3) begin
            rand_x();
            step();
        end
        rst_n = 1'b0;
        rand_x();
        step();
        rst_n = 1'b1;
        rand_x();
        step();
        dvld = 1'b0;
        repeat (4) step();

        // Random mix of valid, backpressure and enable.
        repeat (200) begin
            rand_x();
            dvld  = 1'($urandom_range(0, 1));
            o_rdy = ($urandom_range(0, 3) != 0);
            ena   = ($urandom_range(0, 7) != 0);
            step();
        end
        ena   = 1'b1;
        o_rdy = 1'b1;
        dvld  = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
